byte_op_ctrl: RTL and testbench



---
 rtl/byte_op_ctrl.sv | 175 +++++++++++++++++
 tb/tb_byte_op_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_op_ctrl.sv
// XM-23 byte-op sequencer (MOVL/MOVLZ/MOVLS/MOVH/SWPB): read dst, run byte unit, write back.
// Define BYTE_CTRL_FWD_EN to forward the last written value and skip READ on a hit.
module byte_op_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_dst,
    input  logic [7:0]  cmd_byte,
    output logic        rf_rd_en,
    output logic [2:0]  rf_rd_addr,
    input  logic [15:0] rf_rd_data,
    output logic [2:0]  bm_op,
    output logic [15:0] bm_dst_in,
    output logic [7:0]  bm_byte_val,
    input  logic [15:0] bm_dst_out,
    output logic        rf_wr_en,
    output logic [2:0]  rf_wr_addr,
    output logic [15:0] rf_wr_data,
    input  logic        ext_wr_en,
    input  logic [2:0]  ext_wr_addr,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d, dst_q, dst_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] result_q, result_d;
    logic        err_q, err_d;
    logic        fwd_use_q, fwd_use_d;
    logic [2:0]  bm_op_q, bm_op_d;
    logic [15:0] bm_dst_in_q, bm_dst_in_d;
    logic [7:0]  bm_byte_q, bm_byte_d;
    logic        fwd_hit;
    logic [15:0] exec_src;

`ifdef BYTE_CTRL_FWD_EN
    logic        fwd_vld_q, fwd_vld_d;
    logic [2:0]  fwd_addr_q, fwd_addr_d;
    logic [15:0] fwd_data_q, fwd_data_d;
    logic        ext_hit;

    // An external write landing on the held index this cycle makes the copy stale already.
    assign ext_hit  = ext_wr_en && (ext_wr_addr == fwd_addr_q);
    assign fwd_hit  = fwd_vld_q && !ext_hit && (cmd_dst == fwd_addr_q);
    assign exec_src = fwd_use_q ? fwd_data_q : rf_rd_data;

    always_comb begin
        fwd_vld_d  = fwd_vld_q;
        fwd_addr_d = fwd_addr_q;
        fwd_data_d = fwd_data_q;
        if (state_q == S_WRITE) begin
            fwd_vld_d  = 1'b1;
            fwd_addr_d = dst_q;
            fwd_data_d = result_q;
        end else if (ext_hit) begin
            fwd_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= 3'd0;
            fwd_data_q <= 16'd0;
        end else begin
            fwd_vld_q  <= fwd_vld_d;
            fwd_addr_q <= fwd_addr_d;
            fwd_data_q <= fwd_data_d;
        end
    end
`else
    logic unused_ext;
    assign unused_ext = &{1'b0, ext_wr_en, ext_wr_addr, fwd_use_q};
    assign fwd_hit    = 1'b0;
    assign exec_src   = rf_rd_data;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        byte_d      = byte_q;
        result_d    = result_q;
        err_d       = 1'b0;
        fwd_use_d   = fwd_use_q;
        bm_op_d     = bm_op_q;
        bm_dst_in_d = bm_dst_in_q;
        bm_byte_d   = bm_byte_q;
        cmd_ready   = 1'b0;
        rf_rd_en    = 1'b0;
        rf_rd_addr  = 3'd0;
        rf_wr_en    = 1'b0;
        rf_wr_addr  = 3'd0;
        rf_wr_data  = 16'd0;
        done        = 1'b0;
        bm_op       = bm_op_q;
        bm_dst_in   = bm_dst_in_q;
        bm_byte_val = bm_byte_q;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    dst_d  = cmd_dst;
                    byte_d = cmd_byte;
                    if (cmd_op <= 3'd4) begin
                        fwd_use_d = fwd_hit;
                        state_d   = fwd_hit ? S_EXEC : S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = dst_q;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                // Byte-unit operands are live only here; the _q copies hold them afterwards.
                bm_op       = op_q;
                bm_dst_in   = exec_src;
                bm_byte_val = byte_q;
                bm_op_d     = op_q;
                bm_dst_in_d = exec_src;
                bm_byte_d   = byte_q;
                result_d    = bm_dst_out;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = dst_q;
                rf_wr_data = result_q;
                done       = 1'b1;
                fwd_use_d  = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            dst_q       <= 3'd0;
            byte_q      <= 8'd0;
            result_q    <= 16'd0;
            err_q       <= 1'b0;
            fwd_use_q   <= 1'b0;
            bm_op_q     <= 3'd0;
            bm_dst_in_q <= 16'd0;
            bm_byte_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            byte_q      <= byte_d;
            result_q    <= result_d;
            err_q       <= err_d;
            fwd_use_q   <= fwd_use_d;
            bm_op_q     <= bm_op_d;
            bm_dst_in_q <= bm_dst_in_d;
            bm_byte_q   <= bm_byte_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;
endmodule

// File: tb/tb_byte_op_ctrl.sv
// Directed bench for byte_op_ctrl with a register-file model and a byte-unit model.
module tb_byte_op_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0, cmd_dst = 3'd0;
    logic [7:0]  cmd_byte = 8'd0;
    logic        rf_rd_en;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic [2:0]  bm_op;
    logic [15:0] bm_dst_in;
    logic [7:0]  bm_byte_val;
    logic [15:0] bm_dst_out;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        ext_wr_en = 1'b0;
    logic [2:0]  ext_wr_addr = 3'd0;
    logic [15:0] ext_wr_data = 16'd0;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] rf [8];

    always #5 clk = ~clk;

    byte_op_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_byte(cmd_byte),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .bm_op(bm_op), .bm_dst_in(bm_dst_in), .bm_byte_val(bm_byte_val), .bm_dst_out(bm_dst_out),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr),
        .busy(busy), .done(done), .err(err)
    );

    // Byte-manipulation unit
    always_comb begin
        bm_dst_out = bm_dst_in;
        case (bm_op)
            3'd0: bm_dst_out = {bm_dst_in[15:8], bm_byte_val};
            3'd1: bm_dst_out = {8'h00, bm_byte_val};
            3'd2: bm_dst_out = {8'hFF, bm_byte_val};
            3'd3: bm_dst_out = {bm_byte_val, bm_dst_in[7:0]};
            3'd4: bm_dst_out = {bm_dst_in[7:0], bm_dst_in[15:8]};
            default: bm_dst_out = bm_dst_in;
        endcase
    end

    // Register file: one-cycle read latency, external and controller write ports
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];
        if (ext_wr_en) rf[ext_wr_addr] <= ext_wr_data;
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
        @(posedge clk); #1;
        ext_wr_en = 1'b0;
    endtask

    // Issues one command, then reports the cycle (relative to accept) of its write-back.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [7:0] b,
                           output int lat, output logic [15:0] data, output logic [2:0] addr,
                           output logic rd_seen, output logic dn);
        int w;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_byte = b;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) check("accept_timeout", {15'd0, cmd_ready}, 16'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; data = 16'd0; addr = 3'd0; rd_seen = 1'b0; dn = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rf_rd_en) rd_seen = 1'b1;
            if (rf_wr_en) begin
                lat = c; data = rf_wr_data; addr = rf_wr_addr; dn = done;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [15:0] data;
        logic [2:0]  addr;
        logic        rd, dn, seen;
        int          fwd_lat;
        logic        fwd_rd;
`ifdef BYTE_CTRL_FWD_EN
        fwd_lat = 2; fwd_rd = 1'b0;
`else
        fwd_lat = 3; fwd_rd = 1'b1;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {15'd0, cmd_ready}, 16'd1);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_rd_en", {15'd0, rf_rd_en}, 16'd0);
        check("rst_wr_en", {15'd0, rf_wr_en}, 16'd0);
        check("rst_done_err", {14'd0, done, err}, 16'd0);
        check("rst_bm_dst_in", bm_dst_in, 16'd0);
        check("rst_wr_data", rf_wr_data, 16'd0);
        rst = 1'b0;

        ext_write(3'd3, 16'h1234);
        ext_write(3'd5, 16'h1234);
        ext_write(3'd0, 16'hBEEF);
        ext_write(3'd1, 16'h2222);
        ext_write(3'd4, 16'h4444);
        ext_write(3'd2, 16'h0000);

        // MOVL R3
        run_cmd(3'd0, 3'd3, 8'hAB, lat, data, addr, rd, dn);
        check("movl_lat", 16'(lat), 16'd3);
        check("movl_data", data, 16'h12AB);
        check("movl_addr", {13'd0, addr}, 16'd3);
        check("movl_done", {15'd0, dn}, 16'd1);
        check("movl_read", {15'd0, rd}, 16'd1);

        // MOVLS / MOVLZ R5
        run_cmd(3'd2, 3'd5, 8'h80, lat, data, addr, rd, dn);
        check("movls_data", data, 16'hFF80);
        run_cmd(3'd1, 3'd5, 8'h80, lat, data, addr, rd, dn);
        check("movlz_data", data, 16'h0080);

        // SWPB R0 with the next command held valid while busy
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_dst = 3'd0; cmd_byte = 8'h55;
        @(negedge clk);
        check("swpb_accept", {15'd0, cmd_ready}, 16'd1);
        @(posedge clk); #1;
        cmd_op = 3'd0; cmd_dst = 3'd1; cmd_byte = 8'h33;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("held_ready_low", {15'd0, cmd_ready}, 16'd0);
        end
        check("swpb_wr_en", {15'd0, rf_wr_en}, 16'd1);
        check("swpb_data", rf_wr_data, 16'hEFBE);
        @(negedge clk);
        check("held_accept_c4", {15'd0, cmd_ready}, 16'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0; data = 16'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (rf_wr_en) begin lat = c; data = rf_wr_data; break; end
        end
        check("held_lat", 16'(lat), 16'd3);
        check("held_data", data, 16'h2233);

        // Illegal op
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_dst = 3'd7; cmd_byte = 8'h00;
        @(negedge clk);
        check("ill_accept", {15'd0, cmd_ready}, 16'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ill_err", {15'd0, err}, 16'd1);
        check("ill_busy", {15'd0, busy}, 16'd0);
        check("ill_ready", {15'd0, cmd_ready}, 16'd1);
        seen = rf_rd_en | rf_wr_en | done;
        dn = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            seen = seen | rf_rd_en | rf_wr_en | busy;
            dn = dn | err;
        end
        check("ill_no_rw", {15'd0, seen}, 16'd0);
        check("ill_err_pulse", {15'd0, dn}, 16'd0);

        // Reset during EXEC aborts without write-back
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_dst = 3'd4; cmd_byte = 8'h99;
        @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_read", {15'd0, rf_rd_en}, 16'd1);
        @(negedge clk);
        check("abort_exec_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", {15'd0, busy}, 16'd0);
        check("abort_ready", {15'd0, cmd_ready}, 16'd1);
        seen = rf_wr_en | done;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen = seen | rf_wr_en | done;
        end
        check("abort_no_write", {15'd0, seen}, 16'd0);
        rst = 1'b0;
        run_cmd(3'd0, 3'd4, 8'h77, lat, data, addr, rd, dn);
        check("post_abort_lat", 16'(lat), 16'd3);
        check("post_abort_data", data, 16'h4477);

        // MOVH then MOVL to R2 (back-to-back same register)
        run_cmd(3'd3, 3'd2, 8'h56, lat, data, addr, rd, dn);
        check("movh_data", data, 16'h5600);
        run_cmd(3'd0, 3'd2, 8'h78, lat, data, addr, rd, dn);
        check("r2_data", data, 16'h5678);
        check("r2_lat", 16'(lat), 16'(fwd_lat));
        check("r2_read", {15'd0, rd}, {15'd0, fwd_rd});

        // External write in between defeats forwarding
        run_cmd(3'd3, 3'd2, 8'h9A, lat, data, addr, rd, dn);
        check("movh2_data", data, 16'h9A78);
        ext_write(3'd2, 16'h1111);
        run_cmd(3'd0, 3'd2, 8'hBC, lat, data, addr, rd, dn);
        check("ext_data", data, 16'h11BC);
        check("ext_lat", 16'(lat), 16'd3);
        check("ext_read", {15'd0, rd}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
